// File: rtl/ctrl_pkg.sv
// Shared decode constants and the control word layout for the ID control stage.
// Control word is MSB-first by field; bit 0 is a spare that always reads as zero.
package ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  typedef enum logic [1:0] {
    RD_RT  = 2'b00,
    RD_RD  = 2'b01,
    RD_R31 = 2'b10
  } regdst_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_LOGI  = 2'b11
  } aluop_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BGTZ = 3'b010,
    BR_BLEZ = 3'b011,
    BR_BLTZ = 3'b100,
    BR_BGEZ = 3'b101
  } brop_e;

  typedef struct packed {
    logic    regwrite;
    regdst_e regdst;
    logic    alusrc;
    logic    branch;
    logic    memwrite;
    logic    memtoreg;
    logic    jump;
    logic    jr;
    aluop_e  aluop;
    brop_e   branch_op;
    logic    link;
    logic    hilo_rd;
    logic    hilo_we;
    logic    md_start;
    logic    md_div;
    logic    md_signed;
    logic    illegal;
    logic    spare;
  } ctrl_t;

  localparam int CTRL_W       = $bits(ctrl_t);
  localparam int IDX_REGWRITE = 21;
  localparam int IDX_HILO_RD  = 6;
  localparam int IDX_HILO_WE  = 5;
  localparam int IDX_MD_START = 4;
  localparam int IDX_MD_DIV   = 3;
  localparam int IDX_ILLEGAL  = 1;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational MIPS decode: opcode/rt/funct to control word.
// Anything unrecognised produces only the illegal flag.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rt,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_JR: begin
            ctrl.jump = 1'b1;
            ctrl.jr   = 1'b1;
          end
          F_JALR: begin
            ctrl.jump     = 1'b1;
            ctrl.jr       = 1'b1;
            ctrl.link     = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = RD_RD;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            ctrl.md_start  = 1'b1;
            ctrl.md_div    = funct[1];
            ctrl.md_signed = ~funct[0];
          end
          F_MFHI, F_MFLO: begin
            ctrl.hilo_rd  = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = RD_RD;
          end
          F_MTHI, F_MTLO: ctrl.hilo_we = 1'b1;
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
          F_XOR, F_NOR, F_SLT, F_SLTU: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = RD_RD;
            ctrl.aluop    = ALU_FUNCT;
          end
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        ctrl.branch = 1'b1;
        ctrl.aluop  = ALU_SUB;
        case (rt)
          RT_BLTZ: ctrl.branch_op = BR_BLTZ;
          RT_BGEZ: ctrl.branch_op = BR_BGEZ;
          RT_BLTZAL, RT_BGEZAL: begin
            ctrl.branch_op = rt[0] ? BR_BGEZ : BR_BLTZ;
            ctrl.link      = 1'b1;
            ctrl.regwrite  = 1'b1;
            ctrl.regdst    = RD_R31;
          end
          default: begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump     = 1'b1;
        ctrl.link     = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = RD_R31;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        ctrl.branch = 1'b1;
        ctrl.aluop  = ALU_SUB;
        case (op)
          OP_BNE:  ctrl.branch_op = BR_BNE;
          OP_BLEZ: ctrl.branch_op = BR_BLEZ;
          OP_BGTZ: ctrl.branch_op = BR_BGTZ;
          default: ctrl.branch_op = BR_BEQ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
      end
      // set-less-than immediates compare by subtraction
      OP_SLTI, OP_SLTIU: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_SUB;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_LOGI;
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      OP_SW: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered decode stage: control word pipeline register, handshake,
// flush, and HI/LO hazard stall driven by a MULT/DIV busy counter.
module id_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl
);

  localparam int MAX_CYC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  ctrl_t            dec;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             hz;
  logic             in_xfer;
  logic             out_xfer;
  logic             md_out;

  ctrl_decode u_dec (
    .op    (instr[31:26]),
    .rt    (instr[20:16]),
    .funct (instr[5:0]),
    .ctrl  (dec)
  );

  assign md_out   = out_valid && out_ctrl[IDX_MD_START];
  assign busy     = (cnt != '0) || md_out;
  assign hz       = busy && (dec.hilo_rd || dec.hilo_we || dec.md_start);
  assign in_ready = !flush && (!out_valid || out_ready) && !hz;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      out_ctrl  <= '0;
    end else begin
      if (flush)
        out_valid <= 1'b0;
      else if (in_xfer)
        out_valid <= 1'b1;
      else if (out_xfer)
        out_valid <= 1'b0;
      if (in_xfer) begin
        out_instr <= instr;
        out_pc    <= in_pc;
        out_ctrl  <= dec;
      end
    end
  end

  // a flushed MD entry never reaches the unit, so it must not start the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (out_xfer && out_ctrl[IDX_MD_START] && !flush)
      cnt <= out_ctrl[IDX_MD_DIV] ? CNT_W'(DIV_CYCLES)
                                  : CNT_W'(MULT_CYCLES);
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: directed scenarios plus a randomized run
// against a cycle-level reference model.
module tb_id_ctrl_stage;

  localparam int MC = 4;
  localparam int DC = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [21:0] out_ctrl;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_LW     = 32'h8C480004;
  localparam logic [31:0] I_SW     = 32'hAC480008;
  localparam logic [31:0] I_ADDIU  = 32'h24420001;
  localparam logic [31:0] I_DIV    = 32'h0109001A;
  localparam logic [31:0] I_MULT   = 32'h01090018;
  localparam logic [31:0] I_MULTU  = 32'h01090019;
  localparam logic [31:0] I_MFHI   = 32'h00004010;
  localparam logic [31:0] I_MFLO   = 32'h00004012;
  localparam logic [31:0] I_MTLO   = 32'h01000013;
  localparam logic [31:0] I_JR     = 32'h01000008;
  localparam logic [31:0] I_JALR   = 32'h0100F809;
  localparam logic [31:0] I_BGEZAL = 32'h04110010;
  localparam logic [31:0] I_BLTZ   = 32'h04000003;
  localparam logic [31:0] I_BNE    = 32'h15090004;
  localparam logic [31:0] I_ORI    = 32'h3508FFFF;
  localparam logic [31:0] I_LUI    = 32'h3C081234;
  localparam logic [31:0] I_SLTI   = 32'h2908000A;
  localparam logic [31:0] I_JAL    = 32'h0C000010;
  localparam logic [31:0] I_ADD    = 32'h01095020;
  localparam logic [31:0] I_BADOP  = 32'hFC000000;
  localparam logic [31:0] I_BADFN  = 32'h0000003F;
  localparam logic [31:0] I_BADRT  = 32'h04050000;

  id_ctrl_stage #(.PC_W(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ctrl  (out_ctrl)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Field-by-field decode from the instruction tables, packed in the
  // documented order (regwrite first, one zero spare bit at the end).
  function automatic logic [21:0] ref_ctrl(input logic [31:0] i);
    logic [5:0] op, fn;
    logic [4:0] rt;
    logic rw, asrc, br, mw, m2r, jmp, jr, lnk, hrd, hwe, mds, mdd, mdsg, ill;
    logic [1:0] dst, aop;
    logic [2:0] bop;
    op = i[31:26];
    fn = i[5:0];
    rt = i[20:16];
    {rw, asrc, br, mw, m2r, jmp, jr, lnk} = '0;
    {hrd, hwe, mds, mdd, mdsg, ill} = '0;
    dst = 2'd0;
    aop = 2'd0;
    bop = 3'd0;
    if (op == 6'd0) begin
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                     [6'h20:6'h27], 6'h2A, 6'h2B}) begin
        rw = 1; dst = 2'd1; aop = 2'd2;
      end else if (fn == 6'h08) begin
        jmp = 1; jr = 1;
      end else if (fn == 6'h09) begin
        jmp = 1; jr = 1; lnk = 1; rw = 1; dst = 2'd1;
      end else if (fn inside {[6'h18:6'h1B]}) begin
        mds = 1; mdd = fn[1]; mdsg = !fn[0];
      end else if (fn == 6'h10 || fn == 6'h12) begin
        hrd = 1; rw = 1; dst = 2'd1;
      end else if (fn == 6'h11 || fn == 6'h13) begin
        hwe = 1;
      end else begin
        ill = 1;
      end
    end else if (op == 6'd1) begin
      if (rt inside {5'h00, 5'h01, 5'h10, 5'h11}) begin
        br = 1; aop = 2'd1;
        bop = rt[0] ? 3'd5 : 3'd4;
        if (rt[4]) begin
          lnk = 1; rw = 1; dst = 2'd2;
        end
      end else begin
        ill = 1;
      end
    end else begin
      case (op)
        6'h02: jmp = 1;
        6'h03: begin jmp = 1; lnk = 1; rw = 1; dst = 2'd2; end
        6'h04: begin br = 1; aop = 2'd1; bop = 3'd0; end
        6'h05: begin br = 1; aop = 2'd1; bop = 3'd1; end
        6'h06: begin br = 1; aop = 2'd1; bop = 3'd3; end
        6'h07: begin br = 1; aop = 2'd1; bop = 3'd2; end
        6'h08, 6'h09: begin rw = 1; asrc = 1; end
        6'h0A, 6'h0B: begin rw = 1; asrc = 1; aop = 2'd1; end
        6'h0C, 6'h0D, 6'h0E, 6'h0F: begin rw = 1; asrc = 1; aop = 2'd3; end
        6'h23: begin rw = 1; asrc = 1; m2r = 1; end
        6'h2B: begin asrc = 1; mw = 1; end
        default: ill = 1;
      endcase
    end
    return {rw, dst, asrc, br, mw, m2r, jmp, jr, aop, bop,
            lnk, hrd, hwe, mds, mdd, mdsg, ill, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    instr = I_LW;
    in_pc = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Present one instruction until accepted, bounded.
  task automatic push(input logic [31:0] i, input logic [31:0] pc);
    in_valid = 1'b1;
    instr = i;
    in_pc = pc;
    #1;
    for (int k = 0; k < 100 && !in_ready; k++) begin
      step();
      #1;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_accept instr=%h in_ready=%b want 1", i, in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    instr = I_LW;
    in_pc = 32'h1234;
    #3;
    checks++;
    if ({out_valid, out_ctrl, out_instr, out_pc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b c=%h i=%h pc=%h want all 0",
               out_valid, out_ctrl, out_instr, out_pc);
    end
    checks++;
    if (dut.cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt got %0d want 0", dut.cnt);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_lw();
    do_reset();
    push(I_LW, 32'h100);
    checks++;
    if (out_valid !== 1'b1 || out_ctrl !== 22'h248000 ||
        out_instr !== I_LW || out_pc !== 32'h100) begin
      errors++;
      $display("FAIL lw_decode got v=%b c=%h i=%h pc=%h want 1 248000 %h 100",
               out_valid, out_ctrl, out_instr, out_pc, I_LW);
    end
  endtask

  task automatic test_decode_table();
    logic [31:0] tbl [18];
    tbl = '{I_SW, I_ADDIU, I_MULT, I_MULTU, I_MFHI, I_MTLO, I_JR,
            I_JALR, I_BGEZAL, I_BLTZ, I_BNE, I_ORI, I_LUI, I_SLTI,
            I_JAL, I_ADD, I_BADRT, I_DIV};
    do_reset();
    foreach (tbl[n]) begin
      push(tbl[n], 32'(n * 4));
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== ref_ctrl(tbl[n])) begin
        errors++;
        $display("FAIL decode_%h got v=%b c=%h want 1 %h",
                 tbl[n], out_valid, out_ctrl, ref_ctrl(tbl[n]));
      end
    end
    do_reset();
    push(I_BGEZAL, 32'h40);
    checks++;
    if ({out_ctrl[21:19], out_ctrl[17], out_ctrl[10:7]} !== 8'b110_1_101_1) begin
      errors++;
      $display("FAIL bgezal_fields got ctrl=%h want rw=1 dst=10 br=1 bop=101 link=1",
               out_ctrl);
    end
    push(I_BADOP, 32'h44);
    checks++;
    if (out_valid !== 1'b1 || out_ctrl !== 22'h000002) begin
      errors++;
      $display("FAIL illegal_op got v=%b c=%h want 1 000002", out_valid, out_ctrl);
    end
    push(I_BADFN, 32'h48);
    checks++;
    if (out_valid !== 1'b1 || out_ctrl !== 22'h000002) begin
      errors++;
      $display("FAIL illegal_funct got v=%b c=%h want 1 000002", out_valid, out_ctrl);
    end
  endtask

  task automatic test_div_stall();
    int bad;
    do_reset();
    in_valid = 1'b1;
    instr = I_DIV;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL div_c0_ready got %b want 1", in_ready);
    end
    step();
    instr = I_MFLO;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mflo_c1_stall got %b want 0", in_ready);
    end
    instr = I_ADDIU;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL addiu_c1_ready got %b want 1", in_ready);
    end
    step();
    instr = I_MFLO;
    bad = 0;
    for (int c = 2; c <= 33; c++) begin
      #1;
      if (in_ready !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mflo_stall_2_33 got %0d ready cycles want 0", bad);
    end
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mflo_c34_ready got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== I_MFLO) begin
      errors++;
      $display("FAIL mflo_out got v=%b i=%h want 1 %h", out_valid, out_instr, I_MFLO);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_i;
    logic [21:0] held_c;
    int bad;
    do_reset();
    out_ready = 1'b0;
    push(I_ADDIU, 32'h200);
    held_i = I_ADDIU;
    held_c = ref_ctrl(I_ADDIU);
    in_valid = 1'b1;
    instr = I_LW;
    in_pc = 32'h204;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_instr !== held_i || out_ctrl !== held_c || out_pc !== 32'h200)
        bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold got %0d bad cycles want 0", bad);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_instr !== I_LW || out_pc !== 32'h204 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_next got i=%h pc=%h want %h 204",
               out_instr, out_pc, I_LW);
    end
  endtask

  task automatic test_flush_mult();
    do_reset();
    out_ready = 1'b0;
    push(I_MULT, 32'h300);
    flush = 1'b1;
    in_valid = 1'b1;
    instr = I_ADDIU;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_input got %b want 0", in_ready);
    end
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || dut.cnt !== '0) begin
      errors++;
      $display("FAIL flush_mult got v=%b cnt=%0d want 0 0", out_valid, dut.cnt);
    end
    in_valid = 1'b1;
    instr = I_MFHI;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mfhi_after_flush got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_div();
    do_reset();
    push(I_DIV, 32'h400);
    step();
    step();
    checks++;
    if (dut.cnt == '0) begin
      errors++;
      $display("FAIL div_running got cnt=%0d want nonzero", dut.cnt);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dut.cnt !== '0) begin
      errors++;
      $display("FAIL async_reset got v=%b cnt=%0d want 0 0", out_valid, dut.cnt);
    end
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    instr = I_MFHI;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_accept got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] pool [12];
    logic        m_valid;
    logic [21:0] m_ctrl;
    logic [31:0] m_instr, m_pc;
    int          free_at;
    logic        fl, iv, ordy, er, busy, ox, ix;
    logic [31:0] ins, pc;
    logic [21:0] rc;
    pool = '{I_LW, I_SW, I_ADDIU, I_MULT, I_MULTU, I_DIV, I_MFHI,
             I_MFLO, I_MTLO, I_JR, I_BNE, I_BADFN};
    do_reset();
    m_valid = 1'b0;
    m_ctrl = '0;
    m_instr = '0;
    m_pc = '0;
    free_at = 0;
    for (int t = 0; t < 600; t++) begin
      checks++;
      if (out_valid !== m_valid) begin
        errors++;
        $display("FAIL rand_valid t=%0d got %b want %b", t, out_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if ({out_ctrl, out_instr, out_pc} !== {m_ctrl, m_instr, m_pc}) begin
          errors++;
          $display("FAIL rand_out t=%0d got %h %h %h want %h %h %h", t,
                   out_ctrl, out_instr, out_pc, m_ctrl, m_instr, m_pc);
        end
      end
      fl = ($urandom_range(0, 9) == 0);
      iv = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      ins = pool[$urandom_range(0, 11)] | (32'($urandom_range(0, 31)) << 21);
      pc = $urandom;
      flush = fl;
      in_valid = iv;
      out_ready = ordy;
      instr = ins;
      in_pc = pc;
      #1;
      rc = ref_ctrl(ins);
      busy = (t < free_at) || (m_valid && m_ctrl[4]);
      er = !fl && (!m_valid || ordy) && !(busy && (rc[6] | rc[5] | rc[4]));
      checks++;
      if (in_ready !== er) begin
        errors++;
        $display("FAIL rand_ready t=%0d instr=%h got %b want %b", t, ins, in_ready, er);
      end
      ox = m_valid && ordy;
      ix = iv && er;
      if (ox && !fl && m_ctrl[4])
        free_at = t + 1 + (m_ctrl[3] ? DC : MC);
      if (fl) begin
        m_valid = 1'b0;
      end else if (ix) begin
        m_valid = 1'b1;
        m_ctrl = rc;
        m_instr = ins;
        m_pc = pc;
      end else if (ox) begin
        m_valid = 1'b0;
      end
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_decode_table();
    test_div_stall();
    test_backpressure();
    test_flush_mult();
    test_reset_mid_div();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Registered instruction-decode control stage for the MIPS pipeline. It decodes a 32-bit instruction into a control word and holds it in a one-entry pipeline register with valid/ready handshake and flush. It also tracks the multi-cycle MULT/DIV unit so HI/LO hazards are resolved by stalling at decode. It sits between the IF/ID register and the ID/EX register, and succeeds the combinational main decoder: it adds funct-level decode (JR/JALR, MULT/DIV, MFHI/MTHI), illegal detection and sequential hazard control.

## Interface
Parameters:
- PC_W, 32, width of the PC carried alongside the instruction
- MULT_CYCLES, 4, busy cycles after a MULT/MULTU issues
- DIV_CYCLES, 32, busy cycles after a DIV/DIVU issues
- CNT_W, localparam clog2(max(MULT_CYCLES,DIV_CYCLES)+1), busy counter width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk, input, 1, clock
  - rst, input, 1, async active-high reset
- Input side:
  - in_valid, input, 1, instr/in_pc valid
  - in_ready, output, 1, stage accepts this cycle
  - instr, input, 32, instruction word
  - in_pc, input, PC_W, instruction PC
- Control:
  - flush, input, 1, discard output entry; block input this cycle
- Output side:
  - out_valid, output, 1, output entry valid
  - out_ready, input, 1, downstream accepts
  - out_instr, output, 32, registered instruction
  - out_pc, output, PC_W, registered PC
  - out_ctrl, output, CTRL_W (22), registered control word

## Operation
- out_ctrl fields, MSB first:
  - regwrite
  - regdst[1:0]: 00 rt, 01 rd, 10 r31
  - alusrc, branch, memwrite, memtoreg, jump, jr
  - aluop[1:0]: 00 add, 01 sub, 10 funct, 11 logic-imm zero-extend
  - branch_op[2:0]: 000 beq, 001 bne, 010 bgtz, 011 blez, 100 bltz, 101 bgez
  - link, hilo_rd, hilo_we, md_start, md_div, md_signed, illegal
- Decode coverage and rules:
  - Covers R-type, LW/SW, BEQ/BNE/BGTZ/BLEZ, REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL, ADDI/ADDIU/ANDI/ORI/XORI/SLTI/SLTIU/LUI, J/JAL.
  - Funct-level decode:
    - JR (001000): jump=1, jr=1, regwrite=0.
    - JALR (001001): jump=1, jr=1, link=1, regwrite=1, regdst=01.
    - MULT/MULTU/DIV/DIVU (011000–011011): md_start=1, md_div=funct[1], md_signed=~funct[0], regwrite=0.
    - MFHI/MFLO (010000/010010): hilo_rd=1, regwrite=1, regdst=01.
    - MTHI/MTLO (010001/010011): hilo_we=1, regwrite=0.
  - JAL, BLTZAL and BGEZAL set regdst=10, link=1, regwrite=1.
  - An unknown opcode, REGIMM rt or SPECIAL funct gives an all-zero word except illegal=1. The entry still passes as valid.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !flush && (!out_valid || out_ready) && !hz.
- HI/LO hazard:
  - busy = (cnt != 0) || (out_valid && out_ctrl.md_start).
  - hz = busy && (decoded hilo_rd || hilo_we || md_start).
  - Other instructions proceed while busy.
- Busy counter cnt:
  - Loads MULT_CYCLES or DIV_CYCLES (by md_div) on output transfer of an md_start entry.
  - Otherwise decrements toward 0. Saturates at 0.
  - Load and decrement never coincide, because the output entry cannot be md_start while cnt != 0.
- Flush:
  - Clears out_valid at the next edge. The flushed md_start entry does not load cnt.
  - A counter that is already running continues.
  - Flush wins over a simultaneous input transfer, which cannot occur because in_ready is forced to 0.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_instr=0, out_pc=0, cnt=0. in_ready=1 after reset if flush=0.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 instruction/cycle when out_ready=1 and no hazard.
- in_ready is combinational from out_ready, flush and instr. There is no combinational path from in_valid to out_*.
- Output registers hold their value while out_valid && !out_ready.
- An MD instruction stalls a dependent HI/LO instruction until cnt reaches 0. The dependent instruction is accepted in the cycle where cnt==0 and the output holds no md_start entry.
- Reset asserted mid-operation:
  - Aborts everything immediately (async), including the counter.
  - The first acceptance is possible in the first cycle after rst deasserts.

## Structure
- Package ctrl_pkg:
  - opcode, funct and REGIMM rt constants
  - regdst, aluop and branch_op encodings
  - CTRL_W and field index constants
- Sub-module ctrl_decode: purely combinational instr→ctrl word, including illegal detection.
- id_ctrl_stage holds the pipeline register, handshake, hazard logic and counter.

## Test plan
- LW 0x8C480004, out_ready=1 → next cycle out_valid=1 with regwrite=1, alusrc=1, memtoreg=1, regdst=00, aluop=00, illegal=0.
- DIV 0x0109001A at cycle 0, then MFLO 0x00004012, DIV_CYCLES=32 → MFLO in_ready=0 in cycles 1–33, accepted in cycle 34. An interleaved ADDIU is accepted in cycle 1.
- BGEZAL (op 000001, rt 10001) → regwrite=1, regdst=10, branch=1, branch_op=101, link=1.
- out_ready=0 for 3 cycles with valid input → out_* stable, in_ready=0. The queued instruction is accepted the cycle out_ready returns.
- flush while the output holds MULT → out_valid=0 next cycle and cnt stays 0. A following MFHI is accepted immediately.
- Opcode 0x3F and SPECIAL funct 0x3F → illegal=1, all other fields 0. rst pulse mid-DIV → cnt=0 and out_valid=0 asynchronously.
